// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundle between the fetch/execute control sequencer and the datapath of the
//   8-bit computer.
//
//   master modport : the sequencer (samples opcode, drives state and strobes)
//   slave  modport : the datapath side (drives opcode, observes strobes)
//
//   opcode   IR upper nibble, valid from T4 onward
//   t_state  current T-state, 0..5 = T1..T6
//   halt     processor halted
//   pc_inc / pc_out / pc_load        program counter count / drive / load
//   mar_load                          MAR load
//   ram_out                           RAM drives bus
//   ir_load / ir_out                  IR load / operand nibble drives bus
//   a_load / a_out                    accumulator load / drive bus
//   b_load                            B register load
//   alu_sub / alu_out                 ALU subtract select / result drives bus
//   out_load                          output register load
// -----------------------------------------------------------------------------
interface control_sequencer_if;
   logic [3:0] opcode;
   logic [2:0] t_state;
   logic       halt;
   logic       pc_inc;
   logic       pc_out;
   logic       pc_load;
   logic       mar_load;
   logic       ram_out;
   logic       ir_load;
   logic       ir_out;
   logic       a_load;
   logic       a_out;
   logic       b_load;
   logic       alu_sub;
   logic       alu_out;
   logic       out_load;

   modport master (
      input  opcode,
      output t_state, halt,
      output pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
      output a_load, a_out, b_load, alu_sub, alu_out, out_load
   );

   modport slave (
      output opcode,
      input  t_state, halt,
      input  pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
      input  a_load, a_out, b_load, alu_sub, alu_out, out_load
   );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Six-state T-cycle ring with halt latch, plus the opcode decode that
//   produces the control word for PC, MAR, RAM, IR, A, B, ALU and OUT.
//
//   clk    rising-edge system clock
//   reset  asynchronous, active-high; returns to T1 and clears halt
//   ctl    control_sequencer_if.master: opcode in, t_state/halt/strobes out
//
//   The strobes are a combinational decode of (t_state, halt, opcode): opcode
//   only becomes valid in T4, so the T4 controls cannot be registered ahead.
// -----------------------------------------------------------------------------
module control_sequencer (
   input  logic                       clk,
   input  logic                       reset,
   control_sequencer_if.master        ctl
);

   typedef enum logic [2:0] {
      T1 = 3'd0,
      T2 = 3'd1,
      T3 = 3'd2,
      T4 = 3'd3,
      T5 = 3'd4,
      T6 = 3'd5
   } t_state_e;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_JMP = 4'h4,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef struct packed {
      logic pc_inc;
      logic pc_out;
      logic pc_load;
      logic mar_load;
      logic ram_out;
      logic ir_load;
      logic ir_out;
      logic a_load;
      logic a_out;
      logic b_load;
      logic alu_sub;
      logic alu_out;
      logic out_load;
   } ctl_word_t;

   t_state_e  state_q;
   logic      halt_q;
   ctl_word_t cw;

   // ---------------------------------------------------------------------------
   // State register: ring advances every edge unless halted. HLT in T4 sets
   // halt and leaves the ring parked at T4 (index 3).
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= T1;
         halt_q  <= 1'b0;
      end else if (!halt_q) begin
         if (state_q == T4 && ctl.opcode == OP_HLT) begin
            halt_q <= 1'b1;
         end else begin
            case (state_q)
               T1:      state_q <= T2;
               T2:      state_q <= T3;
               T3:      state_q <= T4;
               T4:      state_q <= T5;
               T5:      state_q <= T6;
               T6:      state_q <= T1;
               default: state_q <= T1;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control decode. Opcode is only consulted in T4-T6, so fetch-phase changes
   // on the opcode lines cannot reach the outputs. Only one bus driver is
   // ever selected per state/opcode pair.
   // ---------------------------------------------------------------------------
   always_comb begin
      cw = '0;
      if (!halt_q) begin
         case (state_q)
            T1: begin
               cw.pc_out   = 1'b1;
               cw.mar_load = 1'b1;
            end
            T2: begin
               cw.pc_inc = 1'b1;
            end
            T3: begin
               cw.ram_out = 1'b1;
               cw.ir_load = 1'b1;
            end
            T4: begin
               case (ctl.opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     cw.ir_out   = 1'b1;
                     cw.mar_load = 1'b1;
                  end
                  OP_JMP: begin
                     cw.ir_out  = 1'b1;
                     cw.pc_load = 1'b1;
                  end
                  OP_OUT: begin
                     cw.a_out    = 1'b1;
                     cw.out_load = 1'b1;
                  end
                  default: cw = '0;
               endcase
            end
            T5: begin
               case (ctl.opcode)
                  OP_LDA: begin
                     cw.ram_out = 1'b1;
                     cw.a_load  = 1'b1;
                  end
                  OP_ADD: begin
                     cw.ram_out = 1'b1;
                     cw.b_load  = 1'b1;
                  end
                  OP_SUB: begin
                     cw.ram_out = 1'b1;
                     cw.b_load  = 1'b1;
                     cw.alu_sub = 1'b1;
                  end
                  default: cw = '0;
               endcase
            end
            T6: begin
               case (ctl.opcode)
                  OP_ADD: begin
                     cw.alu_out = 1'b1;
                     cw.a_load  = 1'b1;
                  end
                  OP_SUB: begin
                     cw.alu_out = 1'b1;
                     cw.a_load  = 1'b1;
                     cw.alu_sub = 1'b1;
                  end
                  default: cw = '0;
               endcase
            end
            default: cw = '0;
         endcase
      end
   end

   assign ctl.t_state  = state_q;
   assign ctl.halt     = halt_q;
   assign ctl.pc_inc   = cw.pc_inc;
   assign ctl.pc_out   = cw.pc_out;
   assign ctl.pc_load  = cw.pc_load;
   assign ctl.mar_load = cw.mar_load;
   assign ctl.ram_out  = cw.ram_out;
   assign ctl.ir_load  = cw.ir_load;
   assign ctl.ir_out   = cw.ir_out;
   assign ctl.a_load   = cw.a_load;
   assign ctl.a_out    = cw.a_out;
   assign ctl.b_load   = cw.b_load;
   assign ctl.alu_sub  = cw.alu_sub;
   assign ctl.alu_out  = cw.alu_out;
   assign ctl.out_load = cw.out_load;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed + randomized bench for control_sequencer. Each cycle the expected
//   {t_state, halt, control word} is pushed when the opcode is driven and
//   popped/compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

   // control word bit positions (bit 12 .. bit 0)
   localparam logic [12:0] PC_INC   = 13'h1000;
   localparam logic [12:0] PC_OUT   = 13'h0800;
   localparam logic [12:0] PC_LOAD  = 13'h0400;
   localparam logic [12:0] MAR_LOAD = 13'h0200;
   localparam logic [12:0] RAM_OUT  = 13'h0100;
   localparam logic [12:0] IR_LOAD  = 13'h0080;
   localparam logic [12:0] IR_OUT   = 13'h0040;
   localparam logic [12:0] A_LOAD   = 13'h0020;
   localparam logic [12:0] A_OUT    = 13'h0010;
   localparam logic [12:0] B_LOAD   = 13'h0008;
   localparam logic [12:0] ALU_SUB  = 13'h0004;
   localparam logic [12:0] ALU_OUT  = 13'h0002;
   localparam logic [12:0] OUT_LOAD = 13'h0001;

   logic clk = 1'b1;
   logic reset;

   control_sequencer_if cs_if ();

   control_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (cs_if)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [2:0]  m_t;
   logic        m_halt;
   logic [16:0] sb_q[$];

   function automatic logic [12:0] obs_ctl();
      return {cs_if.pc_inc, cs_if.pc_out, cs_if.pc_load, cs_if.mar_load,
              cs_if.ram_out, cs_if.ir_load, cs_if.ir_out, cs_if.a_load,
              cs_if.a_out, cs_if.b_load, cs_if.alu_sub, cs_if.alu_out,
              cs_if.out_load};
   endfunction

   function automatic logic [16:0] obs_all();
      return {cs_if.t_state, cs_if.halt, obs_ctl()};
   endfunction

   function automatic int bus_drivers();
      return int'(cs_if.pc_out) + int'(cs_if.ram_out) + int'(cs_if.ir_out) +
             int'(cs_if.a_out) + int'(cs_if.alu_out);
   endfunction

   // reference decode written from the instruction table
   function automatic logic [12:0] exp_ctl(input logic [2:0] t, input logic h,
                                           input logic [3:0] op);
      if (h) return '0;
      case (t)
         3'd0: return PC_OUT | MAR_LOAD;
         3'd1: return PC_INC;
         3'd2: return RAM_OUT | IR_LOAD;
         3'd3: case (op)
                  4'h0, 4'h1, 4'h2: return IR_OUT | MAR_LOAD;
                  4'h4:             return IR_OUT | PC_LOAD;
                  4'hE:             return A_OUT | OUT_LOAD;
                  default:          return '0;
               endcase
         3'd4: case (op)
                  4'h0:    return RAM_OUT | A_LOAD;
                  4'h1:    return RAM_OUT | B_LOAD;
                  4'h2:    return RAM_OUT | B_LOAD | ALU_SUB;
                  default: return '0;
               endcase
         3'd5: case (op)
                  4'h1:    return ALU_OUT | A_LOAD;
                  4'h2:    return ALU_OUT | A_LOAD | ALU_SUB;
                  default: return '0;
               endcase
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_bus(input string tag);
      int n;
      n = bus_drivers();
      tests++;
      assert (n <= 1) else begin
         fails++;
         $error("FAIL %s observed=%0d bus drivers expected<=1", tag, n);
      end
   endtask

   // One clock: drive opcode, push expectation, compare at negedge, step model.
   task automatic cycle(input logic [3:0] op, input string tag);
      logic [16:0] e;
      cs_if.opcode = op;
      sb_q.push_back({m_t, m_halt, exp_ctl(m_t, m_halt, op)});
      @(negedge clk);
      e = sb_q.pop_front();
      chk(tag, obs_all(), e);
      chk_bus({tag, "_bus"});
      @(posedge clk);
      #1;
      if (!m_halt) begin
         if (m_t == 3'd3 && op == 4'hF) m_halt = 1'b1;
         else                           m_t = (m_t == 3'd5) ? 3'd0 : m_t + 3'd1;
      end
   endtask

   // Asynchronous reset between edges, checked before any clock edge.
   task automatic mid_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      chk(tag, obs_all(), {3'd0, 1'b0, PC_OUT | MAR_LOAD});
      reset  = 1'b0;
      m_t    = 3'd0;
      m_halt = 1'b0;
   endtask

   initial begin
      cs_if.opcode = 4'h0;
      reset        = 1'b1;
      m_t          = 3'd0;
      m_halt       = 1'b0;
      #1;
      chk("reset_state", obs_all(), {3'd0, 1'b0, PC_OUT | MAR_LOAD});
      reset = 1'b0;

      // LDA held for two instructions
      for (int i = 0; i < 12; i++) cycle(4'h0, "lda");

      // ADD then SUB
      for (int i = 0; i < 6; i++) cycle(4'h1, "add");
      for (int i = 0; i < 6; i++) cycle(4'h2, "sub");

      // JMP, with explicit T4 and following T1 checks
      for (int i = 0; i < 3; i++) cycle(4'h4, "jmp_fetch");
      cs_if.opcode = 4'h4;
      @(negedge clk);
      chk("jmp_t4", obs_all(), {3'd3, 1'b0, IR_OUT | PC_LOAD});
      @(posedge clk);
      #1;
      m_t = 3'd4;
      cycle(4'h4, "jmp_t5");
      cycle(4'h4, "jmp_t6");
      cycle(4'h4, "jmp_next_t1");

      // finish that instruction as a NOP (unused opcode 0x7)
      for (int i = 0; i < 5; i++) cycle(4'h7, "nop7");
      for (int i = 0; i < 6; i++) cycle(4'h7, "nop7b");

      // OUT then HLT, then 20 halted clocks
      for (int i = 0; i < 6; i++) cycle(4'hE, "out");
      for (int i = 0; i < 4; i++) cycle(4'hF, "hlt");
      for (int i = 0; i < 20; i++) cycle($urandom_range(0, 15), "halted");
      chk("halt_hold", obs_all(), {3'd3, 1'b1, 13'h0000});

      // reset while halted
      mid_reset("reset_in_halt");

      // reset during T5 of ADD (t_state=4)
      for (int i = 0; i < 4; i++) cycle(4'h1, "add_pre");
      chk("add_at_t5", {14'(cs_if.t_state), 3'b000}, {14'd4, 3'b000});
      mid_reset("reset_mid_add");

      // randomized sweep; HLT excluded so the ring keeps running
      for (int i = 0; i < 200; i++) cycle(4'($urandom_range(0, 14)), "sweep");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
